// File: rtl/elixirchip_es1_spu_ctl_pkg.sv
// Shared types for the SPU control path.
// Holds the enable-window generator's FSM state encoding.
package elixirchip_es1_spu_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        ENABLE = 2'd2
    } ctl_enable_gen_state_t;

endpackage

// File: rtl/elixirchip_es1_spu_ctl_beat_counter.sv
// Loadable down-counter used for the skip and length phases of an enable window.
// Changes only on load or dec, so the caller gates both with cke; load wins over dec.
module elixirchip_es1_spu_ctl_beat_counter #(
    parameter int CNT_BITS = 16,
    parameter     DEVICE   = "RTL"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_value,
    input  logic                dec,
    output logic [CNT_BITS-1:0] count,
    output logic                last
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_BITS'(1));

endmodule

// File: rtl/elixirchip_es1_spu_ctl_enable_gen.sv
// Skips SKIP valid beats after a start, then raises m_enable for LEN valid beats and pulses m_done.
// m_enable is a decoded state register, so it lines up with the beat it qualifies.
module elixirchip_es1_spu_ctl_enable_gen
    import elixirchip_es1_spu_ctl_pkg::*;
#(
    parameter int CNT_BITS   = 16,
    parameter     DEVICE     = "RTL",
    parameter     SIMULATION = "false",
    parameter     DEBUG      = "false"
) (
    input  logic                reset,
    input  logic                clk,
    input  logic                cke,
    input  logic                s_start,
    input  logic [CNT_BITS-1:0] s_skip,
    input  logic [CNT_BITS-1:0] s_len,
    input  logic                s_valid,
    output logic                m_enable,
    output logic                m_busy,
    output logic                m_done
);

    (* mark_debug = DEBUG *) ctl_enable_gen_state_t state_q;
    ctl_enable_gen_state_t state_d;
    logic done_q;
    logic done_d;

    logic                skip_load;
    logic                skip_dec;
    logic                skip_last;
    logic [CNT_BITS-1:0] skip_cnt;
    logic                len_load;
    logic                len_dec;
    logic                len_last;
    logic [CNT_BITS-1:0] len_cnt;

    elixirchip_es1_spu_ctl_beat_counter #(
        .CNT_BITS (CNT_BITS),
        .DEVICE   (DEVICE)
    ) u_skip_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (skip_load),
        .load_value (s_skip),
        .dec        (skip_dec),
        .count      (skip_cnt),
        .last       (skip_last)
    );

    elixirchip_es1_spu_ctl_beat_counter #(
        .CNT_BITS (CNT_BITS),
        .DEVICE   (DEVICE)
    ) u_len_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (len_load),
        .load_value (s_len),
        .dec        (len_dec),
        .count      (len_cnt),
        .last       (len_last)
    );

    // A start outranks any count or terminal transition, and its own beat is not counted.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        skip_load = 1'b0;
        skip_dec  = 1'b0;
        len_load  = 1'b0;
        len_dec   = 1'b0;
        if (cke) begin
            done_d = 1'b0;
            if (s_start) begin
                skip_load = 1'b1;
                len_load  = 1'b1;
                if (s_len == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (s_skip != '0) begin
                    state_d = SKIP;
                end else begin
                    state_d = ENABLE;
                end
            end else begin
                case (state_q)
                    SKIP: begin
                        if (s_valid) begin
                            skip_dec = 1'b1;
                            if (skip_last) begin
                                state_d = ENABLE;
                            end
                        end
                    end
                    ENABLE: begin
                        if (s_valid) begin
                            len_dec = 1'b1;
                            if (len_last) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign m_enable = (state_q == ENABLE);
    assign m_busy   = (state_q != IDLE);
    assign m_done   = done_q;

    if (SIMULATION == "true") begin : g_sim_checks
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!m_enable || m_busy);
                assert (!m_done || !m_enable);
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_ctl_enable_gen.sv
// Bench for the enable-window generator: directed scenarios plus random traffic,
// all checked against a beat-position model of the window.
module tb_elixirchip_es1_spu_ctl_enable_gen;

    localparam int CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic          s_start;
    logic [CB-1:0] s_skip;
    logic [CB-1:0] s_len;
    logic          s_valid;
    logic          m_enable;
    logic          m_busy;
    logic          m_done;

    elixirchip_es1_spu_ctl_enable_gen #(
        .CNT_BITS   (CB),
        .DEVICE     ("RTL"),
        .SIMULATION ("true"),
        .DEBUG      ("false")
    ) dut (
        .reset    (reset),
        .clk      (clk),
        .cke      (cke),
        .s_start  (s_start),
        .s_skip   (s_skip),
        .s_len    (s_len),
        .s_valid  (s_valid),
        .m_enable (m_enable),
        .m_busy   (m_busy),
        .m_done   (m_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Window model: position = accepted beats since start; enable while skip <= pos < skip+len.
    bit mdl_busy = 1'b0;
    bit mdl_done = 1'b0;
    int mdl_pos  = 0;
    int mdl_skip = 0;
    int mdl_len  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".m_enable"}, 32'(m_enable), 32'(mdl_busy && (mdl_pos >= mdl_skip)));
        check_val({tag, ".m_busy"},   32'(m_busy),   32'(mdl_busy));
        check_val({tag, ".m_done"},   32'(m_done),   32'(mdl_done));
    endtask

    task automatic step(input string tag, input bit c, input bit st, input int sk, input int ln,
                        input bit v);
        cke     = c;
        s_start = st;
        s_skip  = CB'(sk);
        s_len   = CB'(ln);
        s_valid = v;
        @(posedge clk);
        #1;
        if (c) begin
            if (st) begin
                mdl_done = (ln == 0);
                mdl_busy = (ln != 0);
                mdl_pos  = 0;
                mdl_skip = sk;
                mdl_len  = ln;
            end else begin
                mdl_done = 1'b0;
                if (mdl_busy && v) begin
                    mdl_pos++;
                    if (mdl_pos == mdl_skip + mdl_len) begin
                        mdl_busy = 1'b0;
                        mdl_done = 1'b1;
                    end
                end
            end
        end
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag, input bit c);
        reset   = 1'b1;
        cke     = c;
        s_start = 1'b0;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        mdl_busy = 1'b0;
        mdl_done = 1'b0;
        mdl_pos  = 0;
        check_outputs(tag);
        reset = 1'b0;
    endtask

    initial begin
        bit pat4 [5];
        s_skip = '0;
        s_len  = '0;
        do_reset("reset", 1'b0);

        for (int i = 0; i < 5; i++) step("idle", 1, 0, 0, 0, 0);

        // skip 2 / len 3 with continuous valid
        step("w23.start", 1, 1, 2, 3, 1);
        for (int i = 0; i < 7; i++) step("w23", 1, 0, 0, 0, 1);

        // empty window: done next cycle, no enable
        step("w00.start", 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("w00", 1, 0, 0, 0, 1);
        step("w30.start", 1, 1, 3, 0, 1);
        step("w30", 1, 0, 0, 0, 1);

        // sparse valid pattern
        pat4 = '{0, 1, 0, 1, 1};
        step("w12.start", 1, 1, 1, 2, 0);
        for (int i = 0; i < 5; i++) step("w12", 1, 0, 0, 0, pat4[i]);
        step("w12.tail", 1, 0, 0, 0, 1);

        // cke freeze mid-ENABLE, including a frozen done pulse
        step("frz.start", 1, 1, 0, 5, 1);
        step("frz", 1, 0, 0, 0, 1);
        step("frz", 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("frz.cke0", 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("frz.resume", 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("frz.done_hold", 0, 0, 0, 0, 1);
        step("frz.done_clr", 1, 0, 0, 0, 0);

        // restart while two beats remain
        step("rst.start", 1, 1, 0, 5, 1);
        for (int i = 0; i < 3; i++) step("rst.pre", 1, 0, 0, 0, 1);
        step("rst.restart", 1, 1, 0, 4, 1);
        for (int i = 0; i < 6; i++) step("rst.post", 1, 0, 0, 0, 1);

        // restart into a skip window on the terminal beat
        step("rt.start", 1, 1, 0, 2, 1);
        step("rt", 1, 0, 0, 0, 1);
        step("rt.restart", 1, 1, 2, 1, 1);
        for (int i = 0; i < 4; i++) step("rt.post", 1, 0, 0, 0, 1);

        // reset mid-window
        step("rmw.start", 1, 1, 1, 3, 1);
        step("rmw", 1, 0, 0, 0, 1);
        do_reset("rmw.reset", 1'b1);
        step("rmw.after", 1, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 5)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
